// File: rtl/spike_detection_avalon.sv
// Spike detector with an Avalon-MM slave for control, status and a 64-sample capture window.
// A sample deviating from the 16-sample running mean by more than THRESH triggers a capture.
`timescale 1ns/1ps
module spike_detection_avalon #(
    parameter int unsigned ERRNO = 0
) (
    input  logic        avl_clk_i,
    input  logic        avl_reset_i,
    input  logic [13:0] avl_address_i,
    input  logic [3:0]  avl_byteenable_i,
    input  logic        avl_write_i,
    input  logic [15:0] avl_writedata_i,
    input  logic        avl_read_i,
    output logic        avl_readdatavalid_o,
    output logic [15:0] avl_readdata_o,
    output logic        avl_waitrequest_o,
    output logic        avl_irq_o,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i
);

    localparam logic [15:0] IdValue     = 16'hCAFE;
    localparam logic [15:0] ThreshReset = 16'h0100;

    typedef enum logic [1:0] {StIdle, StCapture, StReady} state_e;

    state_e      state_q, state_d;
    logic        enable_q;
    logic [15:0] thresh_q;
    logic [15:0] count_q;
    logic [4:0]  fill_q;
    logic [5:0]  wr_idx_q;
    logic [19:0] sum_q, sum_d;
    logic [15:0] hist_q [16];
    logic [15:0] window_mem [64];
    logic        rdvalid_q;
    logic [15:0] rdata_q, rdata_d;

    logic        win_sel, ctrl_wr, ack_wr, thresh_wr, disable_wr;
    logic        accept, armed, spike, capture_wr;
    logic        capturing, window_ready, capture_start, capture_done;
    logic [17:0] sample_ext, mean_ext, diff, abs_diff;
    logic        unused_ok;

    assign unused_ok = ^{avl_byteenable_i, 1'(ERRNO != 0)};

    assign win_sel    = (avl_address_i[13:6] == 8'h40);
    assign ctrl_wr    = avl_write_i && (avl_address_i == 14'd1);
    assign ack_wr     = avl_write_i && (avl_address_i == 14'd3);
    assign thresh_wr  = avl_write_i && (avl_address_i == 14'd4);
    assign disable_wr = ctrl_wr && !avl_writedata_i[0];

    assign accept = enable_q && sample_valid_i;
    assign armed  = fill_q[4];

    // Mean excludes the current sample; 18 bits hold any 16-bit difference without overflow.
    assign sample_ext = {{2{sample_i[15]}}, sample_i};
    assign mean_ext   = {{2{sum_q[19]}}, sum_q[19:4]};
    assign diff       = sample_ext - mean_ext;
    assign abs_diff   = diff[17] ? (18'd0 - diff) : diff;
    assign spike      = armed && (abs_diff > {2'b00, thresh_q});

    assign sum_d = sum_q + {{4{sample_i[15]}}, sample_i} - {{4{hist_q[0][15]}}, hist_q[0]};

    // FSM state register
    always_ff @(posedge avl_clk_i) begin
        if (avl_reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && spike && !disable_wr) state_d = StCapture;
            end
            StCapture: begin
                if (disable_wr) begin
                    state_d = StIdle;
                end else if (accept && (wr_idx_q == 6'd63)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (ack_wr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        capturing     = (state_q == StCapture);
        window_ready  = (state_q == StReady);
        capture_start = (state_q == StIdle) && (state_d == StCapture);
        capture_done  = (state_q == StCapture) && (state_d == StReady);
        capture_wr    = (state_q == StCapture) && accept && !disable_wr;
    end

    always_ff @(posedge avl_clk_i) begin
        if (avl_reset_i) begin
            enable_q  <= 1'b0;
            thresh_q  <= ThreshReset;
            count_q   <= '0;
            fill_q    <= '0;
            wr_idx_q  <= '0;
            sum_q     <= '0;
            rdvalid_q <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < 16; i++) hist_q[i] <= '0;
        end else begin
            if (ctrl_wr) enable_q <= avl_writedata_i[0];
            if (thresh_wr) thresh_q <= avl_writedata_i;
            if (capture_done) count_q <= count_q + 16'd1;
            // Disabling disarms; enabling from disabled restarts the history fill.
            if (ctrl_wr && (!avl_writedata_i[0] || !enable_q)) begin
                fill_q <= '0;
            end else if (accept && !fill_q[4]) begin
                fill_q <= fill_q + 5'd1;
            end
            if (capture_start) begin
                wr_idx_q <= 6'd17;
            end else if (capture_wr) begin
                wr_idx_q <= wr_idx_q + 6'd1;
            end
            if (accept) begin
                for (int i = 0; i < 15; i++) hist_q[i] <= hist_q[i+1];
                hist_q[15] <= sample_i;
                sum_q      <= sum_d;
            end
            rdvalid_q <= avl_read_i;
            if (avl_read_i) rdata_q <= rdata_d;
        end
    end

    // Window storage carries no reset; every entry is rewritten before a window completes.
    always_ff @(posedge avl_clk_i) begin
        if (!avl_reset_i) begin
            if (capture_start) begin
                for (int i = 0; i < 16; i++) window_mem[i] <= hist_q[i];
                window_mem[16] <= sample_i;
            end else if (capture_wr) begin
                window_mem[wr_idx_q] <= sample_i;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (win_sel) begin
            rdata_d = window_mem[avl_address_i[5:0]];
        end else begin
            case (avl_address_i)
                14'd0:   rdata_d = IdValue;
                14'd1:   rdata_d = {15'd0, enable_q};
                14'd2:   rdata_d = {13'd0, capturing, window_ready, enable_q};
                14'd4:   rdata_d = thresh_q;
                14'd5:   rdata_d = count_q;
                default: rdata_d = '0;
            endcase
        end
    end

    assign avl_readdatavalid_o = rdvalid_q;
    assign avl_readdata_o      = rdata_q;
    assign avl_waitrequest_o   = 1'b0;
    assign avl_irq_o           = window_ready;

endmodule

// File: tb/tb_spike_detection_avalon.sv
// Bench for spike_detection_avalon: directed scenarios plus randomized traffic,
// reads checked by a scoreboard against a queue-based reference model.
`timescale 1ns/1ps
module tb_spike_detection_avalon;

    logic        clk;
    logic        rst;
    logic [13:0] address;
    logic [3:0]  byteenable;
    logic        write;
    logic [15:0] writedata;
    logic        read;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        irq;
    logic [15:0] sample;
    logic        sample_valid;

    spike_detection_avalon #(.ERRNO(0)) dut (
        .avl_clk_i          (clk),
        .avl_reset_i        (rst),
        .avl_address_i      (address),
        .avl_byteenable_i   (byteenable),
        .avl_write_i        (write),
        .avl_writedata_i    (writedata),
        .avl_read_i         (read),
        .avl_readdatavalid_o(readdatavalid),
        .avl_readdata_o     (readdata),
        .avl_waitrequest_o  (waitrequest),
        .avl_irq_o          (irq),
        .sample_i           (sample),
        .sample_valid_i     (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    data;
        int    cyc;
        string name;
    } exp_t;
    exp_t rq[$];
    exp_t mon_e;

    // Reference model: plain behavioural state.
    bit m_en, m_cap, m_ready;
    int m_fill, m_widx, m_count, m_thresh;
    int m_win[64];
    int hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (readdatavalid) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_readdatavalid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                mon_e = rq.pop_front();
                check({mon_e.name, "_data"}, {16'd0, readdata}, mon_e.data);
                check({mon_e.name, "_latency"}, cyc, mon_e.cyc + 1);
            end
        end
    end

    function automatic void model_reset();
        m_en = 0; m_cap = 0; m_ready = 0;
        m_fill = 0; m_widx = 0; m_count = 0; m_thresh = 256;
        hist.delete();
        repeat (16) hist.push_back(0);
    endfunction

    function automatic void model_feed(int s);
        int sm;
        int mean;
        int d;
        if (!m_en) return;
        sm = 0;
        foreach (hist[i]) sm += hist[i];
        mean = sm >>> 4;
        d = s - mean;
        if (d < 0) d = -d;
        if (m_cap) begin
            m_win[m_widx] = s;
            m_widx++;
            if (m_widx == 64) begin
                m_cap = 0;
                m_ready = 1;
                m_count = (m_count + 1) & 'hFFFF;
            end
        end else if (!m_ready && m_fill >= 16 && d > m_thresh) begin
            for (int i = 0; i < 16; i++) m_win[i] = hist[i];
            m_win[16] = s;
            m_widx = 17;
            m_cap = 1;
        end
        void'(hist.pop_front());
        hist.push_back(s);
        if (m_fill < 16) m_fill++;
    endfunction

    function automatic void model_write(int addr, int data);
        if (addr == 1) begin
            if (data[0]) begin
                if (!m_en) m_fill = 0;
                m_en = 1;
            end else begin
                m_en = 0;
                m_cap = 0;
                m_fill = 0;
            end
        end else if (addr == 3) begin
            m_ready = 0;
        end else if (addr == 4) begin
            m_thresh = data & 'hFFFF;
        end
    endfunction

    function automatic int model_read(int addr);
        if (addr >= 'h1000 && addr <= 'h103F) return m_win[addr - 'h1000] & 'hFFFF;
        case (addr)
            0: return 'hCAFE;
            1: return int'(m_en);
            2: return int'(m_en) | (int'(m_ready) << 1) | (int'(m_cap) << 2);
            4: return m_thresh;
            5: return m_count;
            default: return 0;
        endcase
    endfunction

    task automatic bus_write(input int addr, input int data);
        address   = addr[13:0];
        writedata = data[15:0];
        write     = 1'b1;
        @(posedge clk);
        model_write(addr, data);
        #1;
        write = 1'b0;
    endtask

    task automatic bus_read_exp(input int addr, input int exp, input string name);
        exp_t e;
        e.data = exp & 'hFFFF;
        e.cyc  = cyc;
        e.name = name;
        rq.push_back(e);
        address = addr[13:0];
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic bus_read_model(input int addr);
        bus_read_exp(addr, model_read(addr), $sformatf("read_0x%0h", addr));
    endtask

    task automatic feed(input int s, input bit v);
        sample       = s[15:0];
        sample_valid = v;
        @(posedge clk);
        if (v) model_feed(s);
        #1;
        sample_valid = 1'b0;
        check("irq", {31'd0, irq}, {31'd0, m_ready});
    endtask

    task automatic feed_zeros(input int n);
        for (int i = 0; i < n; i++) feed(0, 1'b1);
    endtask

    // Reset with a conflicting write and read presented; reset must win.
    task automatic do_reset();
        rst       = 1'b1;
        address   = 14'd4;
        writedata = 16'h0005;
        write     = 1'b1;
        read      = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst   = 1'b0;
        write = 1'b0;
        read  = 1'b0;
    endtask

    function automatic int rnd_sample();
        int r;
        int mag;
        r = int'($urandom_range(0, 99));
        if (r < 86) return int'($urandom_range(0, 120)) - 60;
        if (r == 98) return 32767;
        if (r == 99) return -32768;
        mag = int'($urandom_range(150, 32000));
        return ($urandom_range(0, 1) != 0) ? mag : -mag;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int a;
        rst = 1'b1; address = '0; byteenable = 4'hF; write = 1'b0; writedata = '0;
        read = 1'b0; sample = '0; sample_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check("readdata_after_reset", {16'd0, readdata}, 32'd0);
        check("rdvalid_after_reset", {31'd0, readdatavalid}, 32'd0);
        check("irq_after_reset", {31'd0, irq}, 32'd0);
        check("waitrequest", {31'd0, waitrequest}, 32'd0);

        // Register map basics and reset values
        bus_read_exp(0, 'hCAFE, "id");
        bus_read_exp('h2000, 0, "unmapped");
        bus_read_exp(4, 'h0100, "thresh_reset");
        bus_read_exp(5, 0, "count_reset");
        bus_read_exp(2, 0, "status_reset");
        bus_read_exp(1, 0, "ctrl_reset");
        bus_read_exp(3, 0, "ack_reads_zero");

        // Spike before arming is ignored
        bus_write(1, 1);
        bus_write(4, 100);
        feed_zeros(5);
        feed(500, 1'b1);
        bus_read_exp(2, 1, "status_unarmed_spike");

        // Basic capture
        do_reset();
        bus_write(1, 1);
        bus_write(4, 100);
        feed_zeros(20);
        feed(500, 1'b1);
        bus_read_exp(2, 5, "status_capturing");
        feed_zeros(46);
        check("irq_before_47th", {31'd0, irq}, 32'd0);
        feed(0, 1'b1);
        check("irq_on_47th", {31'd0, irq}, 32'd1);
        bus_read_exp(2, 3, "status_ready");
        bus_read_exp('h1010, 500, "win16");
        for (int i = 0; i < 16; i++) bus_read_exp('h1000 + i, 0, $sformatf("win%0d", i));
        bus_read_exp('h1011, 0, "win17");
        bus_read_exp('h103F, 0, "win63");
        bus_read_exp(5, 1, "count_one");

        // Spike while window pending is ignored; ACK re-opens detection
        feed(-400, 1'b1);
        bus_read_exp(2, 3, "status_spike_while_ready");
        bus_read_exp(5, 1, "count_unchanged");
        bus_write(3, 0);
        check("irq_after_ack", {31'd0, irq}, 32'd0);
        feed(500, 1'b1);
        bus_read_exp(2, 5, "status_recapture");

        // Abort mid-capture, then re-arm from scratch
        feed_zeros(10);
        bus_write(1, 0);
        bus_read_exp(2, 0, "status_aborted");
        bus_write(1, 1);
        feed_zeros(15);
        feed(500, 1'b1);
        bus_read_exp(2, 1, "status_rearm_15");
        feed_zeros(16);
        feed(500, 1'b1);
        bus_read_exp(2, 5, "status_rearmed_capture");
        feed_zeros(47);
        bus_read_exp(5, 2, "count_two");
        bus_read_exp('h1010, 500, "win16_second");
        bus_write(3, 0);

        // Threshold boundary, both signs
        feed(100, 1'b1);
        bus_read_exp(2, 1, "thresh_eq_pos");
        feed_zeros(16);
        feed(101, 1'b1);
        bus_read_exp(2, 5, "thresh_gt_pos");
        bus_write(1, 0);
        bus_write(1, 1);
        feed_zeros(16);
        feed(-100, 1'b1);
        bus_read_exp(2, 1, "thresh_eq_neg");
        feed_zeros(16);
        feed(-101, 1'b1);
        bus_read_exp(2, 5, "thresh_gt_neg");

        // Reset mid-capture abandons it
        feed_zeros(10);
        do_reset();
        check("irq_after_midcap_reset", {31'd0, irq}, 32'd0);
        bus_read_exp(2, 0, "status_after_midcap_reset");
        bus_read_exp(4, 'h0100, "thresh_reset_wins");

        // Randomized traffic against the model
        bus_write(1, 1);
        bus_write(4, int'($urandom_range(40, 300)));
        for (int it = 0; it < 4000; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                feed(rnd_sample(), ($urandom_range(0, 9) != 0));
            end else if (r < 78) begin
                a = int'($urandom_range(0, 6));
                if (a == 6) a = 'h2000 + int'($urandom_range(0, 100));
                bus_read_model(a);
            end else if (r < 84) begin
                if (m_ready) bus_read_model('h1000 + int'($urandom_range(0, 63)));
                else bus_read_model(2);
            end else if (r < 87) begin
                if (m_ready || $urandom_range(0, 3) == 0) bus_write(3, int'($urandom_range(0, 65535)));
                else feed(rnd_sample(), 1'b1);
            end else if (r == 87) begin
                a = int'($urandom_range(0, 65535)) & 'hFFFE;
                if (m_en && $urandom_range(0, 2) == 0) bus_write(1, a);
                else bus_write(1, a | 1);
            end else if (r == 88) begin
                bus_write(4, int'($urandom_range(0, 400)));
            end else if (r == 89) begin
                case ($urandom_range(0, 3))
                    0: a = 0;
                    1: a = 2;
                    2: a = 5;
                    default: a = 'h1000 + int'($urandom_range(0, 63));
                endcase
                bus_write(a, int'($urandom_range(0, 65535)));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        bus_read_model(5);
        bus_read_model(2);

        repeat (3) @(posedge clk);
        #1;
        check("pending_reads", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
